inv_sub_bytes_iter: RTL and testbench
=====================================

// Module: inv_sub_bytes_iter
// PURPOSE
//  Iterative AES InvSubBytes for the decryption datapath: applies the inverse S-box to every byte of a 128-bit state.
//  Processes BYTES_PER_CYCLE bytes per clock through one shared inverse-S-box bank, trading latency for area.
//  Sits between InvShiftRows and AddRoundKey in the decrypt round loop, with valid/ready on both sides.
// PARAMETERS
//  BYTES_PER_CYCLE  4  bytes substituted per cycle; legal values 1, 2, 4, 8, 16. Values 4, 8 and 16 use whole inv_sub_word lanes.
//  NUM_STEPS        16/BYTES_PER_CYCLE  derived localparam, not overridable.
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    synchronous active-low reset
//  in_valid   in   1    StateIn is valid
//  in_ready   out  1    block can accept a state
//  StateIn    in   128  input state; byte k = StateIn[8k+7:8k]
//  out_valid  out  1    StateOut holds a completed result
//  out_ready  in   1    downstream accepts StateOut
//  StateOut   out  128  inverse-substituted state; same byte ordering as StateIn
//  busy       out  1    high while in BUSY
// BEHAVIOUR
//  FSM states: IDLE, BUSY, DONE.
//  Reset (rst_n==0 at a clk edge): state=IDLE, step counter=0, StateOut=0, out_valid=0, in_ready=1 after the edge, busy=0.
//  Reset mid-operation discards any partial or unconsumed result.
//  IDLE:
//   - in_ready=1.
//   - On in_valid: latch StateIn into the work register, clear the step counter, go to BUSY.
//  BUSY:
//   - in_ready=0, busy=1.
//   - Each cycle, step s replaces bytes [s*BPC .. s*BPC+BPC-1] with InvSBox(byte). Other bytes are held.
//   - The counter increments each cycle. On step NUM_STEPS-1, go to DONE.
//  DONE:
//   - out_valid=1 and StateOut = work register. Both stay stable until out_ready is sampled high.
//   - On out_ready: out_valid drops at the next edge and the FSM returns to IDLE.
//   - No bypass: a new state is accepted only in IDLE, so a DONE->IDLE transition is never combined with an accept.
//   - Throughput: one state per NUM_STEPS+2 cycles.
//  Latency: accept edge to out_valid = NUM_STEPS cycles (4 for the default).
//  Counter width: $clog2(NUM_STEPS), minimum 1 bit. It wraps to 0 only through the DONE->IDLE path.
//  in_valid while in BUSY or DONE is ignored, and the source must hold the state (in_ready=0).
//  If out_ready is already high when DONE is entered, the handshake completes on the first DONE cycle.
//  StateOut is registered. All bytes not yet processed remain the raw input during BUSY, and StateOut is not updated until DONE.
//  The inverse S-box is purely combinational, using the FIPS-197 inverse table (InvSBox(0x63)=0x00).
// STRUCTURE
//  Shared package aes_pkg:
//   - INV_SBOX_TABLE: 256x8 constant.
//   - Function inv_sbox(byte).
//   - Typedef aes_state_t (128-bit).
//   - Constant AES_STATE_BYTES=16.
//  Sub-module inv_sub_word:
//   - 32-bit DataIn/DataOut with four inv_sbox lanes.
//   - Byte ordering matches the forward word substitution: byte 0 = DataIn[7:0].
//   - Instantiated BYTES_PER_CYCLE/4 times when BPC>=4. Otherwise inv_sbox is called directly.
//  Local to this block: the FSM, the step counter, and the work-register byte mux.
// TESTING
//  1. State bytes all 0x63, BPC=4, out_ready=1 -> out_valid exactly 4 cycles after accept; StateOut=128'h0.
//  2. StateIn = SubBytes(00..0F) = 128'h76ABD7FE2B670130C56F6BF27B777C63 -> StateOut = 128'h0F0E0D0C0B0A09080706050403020100.
//  3. Backpressure: hold out_ready=0 for 10 cycles in DONE -> StateOut/out_valid stable, in_ready=0, a second in_valid is not accepted.
//  4. Assert rst_n=0 on BUSY step 2 -> next cycle IDLE, out_valid=0, StateOut=0. Then a fresh state 0x16 repeated -> all 0xFF.
//  5. Parameter sweep BPC=1,2,8,16 on random states -> latency 16/8/2/1 cycles; result equals the per-byte reference model.
//  6. Back-to-back: in_valid held high with 100 random states -> every state accepted once, results in order, one per NUM_STEPS+2 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, state type and inverse S-box lookup
package aes_pkg;

  localparam int AES_STATE_BYTES = 16;

  typedef logic [127:0] aes_state_t;

  localparam logic [7:0] INV_SBOX_TABLE [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX_TABLE[b];
  endfunction

endpackage

// File: rtl/inv_sub_word.sv
// rtl/inv_sub_word.sv - four-lane inverse S-box on a 32-bit word, byte 0 = DataIn[7:0]
module inv_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut
);

  for (genvar lane = 0; lane < 4; lane++) begin : gLane
    assign DataOut[8*lane +: 8] = inv_sbox(DataIn[8*lane +: 8]);
  end

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// rtl/inv_sub_bytes_iter.sv - iterative InvSubBytes, BYTES_PER_CYCLE bytes per clock through a shared bank
module inv_sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
)(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] StateIn,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] StateOut,
  output logic         busy
);

  localparam int NUM_STEPS = AES_STATE_BYTES / BYTES_PER_CYCLE;
  localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int CHUNK_W   = 8 * BYTES_PER_CYCLE;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_state_t;

  fsm_state_t         state, stateNext;
  logic [CNT_W-1:0]   stepCnt;
  aes_state_t         workReg, workNext, outReg;
  logic [CHUNK_W-1:0] curChunk, subChunk;
  logic               lastStep;

  assign lastStep = (stepCnt == CNT_W'(NUM_STEPS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) stateNext = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (lastStep) stateNext = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Select the chunk addressed by the step counter; untouched bytes keep the raw input.
  always_comb begin
    curChunk = '0;
    for (int s = 0; s < NUM_STEPS; s++)
      if (stepCnt == CNT_W'(s)) curChunk = workReg[s*CHUNK_W +: CHUNK_W];
  end

  if (BYTES_PER_CYCLE >= 4) begin : gWords
    for (genvar w = 0; w < BYTES_PER_CYCLE / 4; w++) begin : gWord
      inv_sub_word uInvSubWord (
        .DataIn  (curChunk[32*w +: 32]),
        .DataOut (subChunk[32*w +: 32])
      );
    end
  end else begin : gBytes
    for (genvar b = 0; b < BYTES_PER_CYCLE; b++) begin : gByte
      assign subChunk[8*b +: 8] = inv_sbox(curChunk[8*b +: 8]);
    end
  end

  always_comb begin
    workNext = workReg;
    for (int s = 0; s < NUM_STEPS; s++)
      if (stepCnt == CNT_W'(s)) workNext[s*CHUNK_W +: CHUNK_W] = subChunk;
  end

  // Counter holds on the final step so it only returns to zero via DONE->IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stepCnt <= '0;
      workReg <= '0;
      outReg  <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          workReg <= StateIn;
          stepCnt <= '0;
        end
        BUSY: begin
          workReg <= workNext;
          if (lastStep) outReg <= workNext;
          else          stepCnt <= stepCnt + CNT_W'(1);
        end
        DONE: if (out_ready) stepCnt <= '0;
        default: ;
      endcase
    end
  end

  assign StateOut = outReg;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// tb/tb_inv_sub_bytes_iter.sv - bench for inv_sub_bytes_iter across BYTES_PER_CYCLE 1..16
module tb_inv_sub_bytes_iter;

  localparam int NCFG = 5;
  localparam int MAIN = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         inValid  [NCFG];
  logic         inReady  [NCFG];
  logic         outValid [NCFG];
  logic         outReady [NCFG];
  logic         busyS    [NCFG];
  logic [127:0] stateIn  [NCFG];
  logic [127:0] stateOut [NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : gDut
    inv_sub_bytes_iter #(.BYTES_PER_CYCLE(1 << g)) uDut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inValid[g]),
      .in_ready  (inReady[g]),
      .StateIn   (stateIn[g]),
      .out_valid (outValid[g]),
      .out_ready (outReady[g]),
      .StateOut  (stateOut[g]),
      .busy      (busyS[g])
    );
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] refInv [256];

  typedef struct {
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;
  vec_t vecs [5];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // Inverse S-box derived from GF(2^8) inversion plus the forward affine map.
  task automatic buildRef();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      refInv[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] refState(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = refInv[s[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic runTxn(input int i, input logic [127:0] din, input logic rdy,
                        output logic [127:0] dout, output int lat);
    int n;
    @(negedge clk);
    outReady[i] = rdy;
    inValid[i]  = 1'b1;
    stateIn[i]  = din;
    n = 0;
    while (!inReady[i] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!inReady[i]) begin
      checks++; errors++;
      $display("FAIL accept_timeout cfg %0d: in_ready stayed 0 expected 1", i);
    end
    @(negedge clk);
    inValid[i] = 1'b0;
    lat = 0;
    while (!outValid[i] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!outValid[i]) begin
      checks++; errors++;
      $display("FAIL result_timeout cfg %0d: out_valid stayed 0 expected 1", i);
    end
    dout = stateOut[i];
  endtask

  initial begin
    logic [127:0] r, held, d;
    int lat, got, accepts, lastCyc, cyc, sent;
    logic [127:0] b2b [100];
    logic pending;

    for (int g = 0; g < NCFG; g++) begin
      inValid[g] = 1'b0; outReady[g] = 1'b0; stateIn[g] = '0;
    end
    rst_n = 1'b0;
    buildRef();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    checkBit("reset_in_ready", inReady[MAIN], 1'b1);
    checkBit("reset_out_valid", outValid[MAIN], 1'b0);
    checkBit("reset_busy", busyS[MAIN], 1'b0);
    check("reset_state_out", stateOut[MAIN], '0);

    vecs[0] = '{{16{8'h63}}, 128'h0};
    vecs[1] = '{128'h76ABD7FE2B670130C56F6BF27B777C63, 128'h0F0E0D0C0B0A09080706050403020100};
    vecs[2] = '{{16{8'h16}}, {16{8'hFF}}};
    vecs[3] = '{128'h0F0E0D0C0B0A09080706050403020100, 128'hFBD7F3819EA340BF38A53630D56A0952};
    vecs[4] = '{128'h0, {16{8'h52}}};
    for (int v = 0; v < 5; v++) begin
      runTxn(MAIN, vecs[v].din, 1'b1, r, lat);
      check($sformatf("vec%0d_out", v), r, vecs[v].dout);
      checkInt($sformatf("vec%0d_latency", v), lat, 4);
    end

    // Backpressure: result must sit stable in DONE and ignore a new offer.
    d = rnd128();
    runTxn(MAIN, d, 1'b0, held, lat);
    check("bp_first", held, refState(d));
    for (int c = 0; c < 10; c++) begin
      inValid[MAIN] = 1'b1;
      stateIn[MAIN] = rnd128();
      @(negedge clk);
      checkBit($sformatf("bp_valid%0d", c), outValid[MAIN], 1'b1);
      check($sformatf("bp_stable%0d", c), stateOut[MAIN], held);
      checkBit($sformatf("bp_in_ready%0d", c), inReady[MAIN], 1'b0);
    end
    inValid[MAIN] = 1'b0;
    outReady[MAIN] = 1'b1;
    @(negedge clk);
    checkBit("bp_release_valid", outValid[MAIN], 1'b0);
    checkBit("bp_release_idle", inReady[MAIN], 1'b1);
    checkBit("bp_no_accept", busyS[MAIN], 1'b0);

    // Reset on BUSY step 2.
    inValid[MAIN] = 1'b1;
    stateIn[MAIN] = rnd128();
    @(negedge clk);
    inValid[MAIN] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkBit("rst_pre_busy", busyS[MAIN], 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkBit("rst_in_ready", inReady[MAIN], 1'b1);
    checkBit("rst_out_valid", outValid[MAIN], 1'b0);
    checkBit("rst_busy", busyS[MAIN], 1'b0);
    check("rst_state_out", stateOut[MAIN], '0);
    runTxn(MAIN, {16{8'h16}}, 1'b1, r, lat);
    check("rst_fresh", r, {16{8'hFF}});

    for (int g = 0; g < NCFG; g++) begin
      for (int t = 0; t < 3; t++) begin
        d = rnd128();
        runTxn(g, d, 1'b1, r, lat);
        check($sformatf("sweep_bpc%0d_out%0d", 1 << g, t), r, refState(d));
        checkInt($sformatf("sweep_bpc%0d_lat%0d", 1 << g, t), lat, 16 >> g);
      end
    end

    // Back-to-back with in_valid held high.
    @(negedge clk);
    for (int k = 0; k < 100; k++) b2b[k] = rnd128();
    sent = 0; got = 0; accepts = 0; lastCyc = -1; cyc = 0; pending = 1'b0;
    outReady[MAIN] = 1'b1;
    inValid[MAIN] = 1'b1;
    stateIn[MAIN] = b2b[0];
    while (got < 100 && cyc < 2000) begin
      if (pending) begin
        pending = 1'b0;
        sent++;
        if (sent < 100) stateIn[MAIN] = b2b[sent];
        else inValid[MAIN] = 1'b0;
      end
      if (inReady[MAIN] && inValid[MAIN]) begin
        pending = 1'b1;
        accepts++;
      end
      @(negedge clk);
      cyc++;
      if (outValid[MAIN]) begin
        check($sformatf("b2b_out%0d", got), stateOut[MAIN], refState(b2b[got]));
        if (lastCyc >= 0) checkInt($sformatf("b2b_gap%0d", got), cyc - lastCyc, 6);
        lastCyc = cyc;
        got++;
      end
    end
    checkInt("b2b_results", got, 100);
    checkInt("b2b_accepts", accepts, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
